// File: rtl/seq_pkg.sv
// Shared types and width helpers for the call-stack program sequencer.
package seq_pkg;

   // Sequencer command encoding. Encodings 6 and 7 are undefined and act as INC.
   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_JMP  = 3'd1,
      OP_JZ   = 3'd2,
      OP_JNZ  = 3'd3,
      OP_CALL = 3'd4,
      OP_RET  = 3'd5
   } seq_op_t;

   localparam int unsigned OP_W = 3;

   // Address bits needed to index a stack of the given depth.
   function automatic int unsigned stack_addr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Occupancy counter width: one extra bit so a full stack (count == depth) is representable.
   function automatic int unsigned stack_count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/lifo_stack.sv
// Return-address LIFO: storage array plus occupancy pointer. Storage is not reset;
// only the pointer is, so stale entries are unreachable once the stack is emptied.
module lifo_stack
   import seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  push,
   input  logic                                  pop,
   input  logic [WIDTH-1:0]                      din,
   output logic [WIDTH-1:0]                      top,
   output logic [stack_count_width(DEPTH)-1:0]   count,
   output logic                                  full,
   output logic                                  empty
);

   localparam int unsigned AW = stack_addr_width(DEPTH);
   localparam int unsigned CW = stack_count_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;

   // The next free slot is the current count; the top entry sits one below it.
   assign wr_idx = count_q[AW-1:0];
   assign rd_idx = count_q[AW-1:0] - AW'(1);

   assign top   = mem[rd_idx];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Pointer update; guards make push-when-full and pop-when-empty harmless no-ops.
   always_comb begin
      count_d = count_q;
      if (push && !full) begin
         count_d = count_q + CW'(1);
      end else if (pop && !empty) begin
         count_d = count_q - CW'(1);
      end
   end

   // Occupancy pointer, cleared asynchronously so a reset drops every entry at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Storage write; a push overwrites whatever a previous pop left behind in that slot.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/call_stack_sequencer.sv
// Program sequencer: registered PC with jump, conditional branch, call and return,
// backed by a small return-address stack and sticky overflow/underflow flags.
module call_stack_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned PC_W        = 8,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned RESET_VEC   = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           stall,
   input  seq_op_t                        op,
   input  logic [PC_W-1:0]                target,
   input  logic                           zero_flag,
   input  logic                           clr_err,
   output logic [PC_W-1:0]                pm_addr,
   output logic [PC_W-1:0]                pc,
   output logic [$clog2(STACK_DEPTH):0]   sp,
   output logic                           stack_full,
   output logic                           stack_empty,
   output logic                           overflow_err,
   output logic                           underflow_err
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic            overflow_err_q, overflow_err_d;
   logic            underflow_err_q, underflow_err_d;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] stack_top;
   logic            push, pop;

   // Natural PC width makes the increment wrap all-ones to zero; it is also the return address.
   assign pc_inc = pc_q + PC_W'(1);

   lifo_stack #(
      .WIDTH (PC_W),
      .DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .rst   (reset),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .top   (stack_top),
      .count (sp),
      .full  (stack_full),
      .empty (stack_empty)
   );

   // Next-PC mux, stack control and error-flag update. Stall freezes everything,
   // including clr_err; a clear and a new error in the same cycle leave the flag set.
   always_comb begin
      pc_d            = pc_q;
      overflow_err_d  = overflow_err_q;
      underflow_err_d = underflow_err_q;
      push            = 1'b0;
      pop             = 1'b0;
      if (!stall) begin
         if (clr_err) begin
            overflow_err_d  = 1'b0;
            underflow_err_d = 1'b0;
         end
         pc_d = pc_inc;
         case (op)
            OP_JMP: pc_d = target;
            OP_JZ:  if (zero_flag)  pc_d = target;
            OP_JNZ: if (!zero_flag) pc_d = target;
            OP_CALL: begin
               if (stack_full) begin
                  overflow_err_d = 1'b1;
               end else begin
                  push = 1'b1;
                  pc_d = target;
               end
            end
            OP_RET: begin
               if (stack_empty) begin
                  underflow_err_d = 1'b1;
               end else begin
                  pop  = 1'b1;
                  pc_d = stack_top;
               end
            end
            default: pc_d = pc_inc;
         endcase
      end
   end

   // PC and sticky error flags; reset is asynchronous and aborts any in-flight op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q            <= PC_W'(RESET_VEC);
         overflow_err_q  <= 1'b0;
         underflow_err_q <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         overflow_err_q  <= overflow_err_d;
         underflow_err_q <= underflow_err_d;
      end
   end

   assign pc            = pc_q;
   assign pm_addr       = pc_q;
   assign overflow_err  = overflow_err_q;
   assign underflow_err = underflow_err_q;

endmodule
